// File: rtl/wb_interconnect_arb_pkg.sv
// Shared definitions for the per-target round-robin Wishbone arbiter.
package wb_interconnect_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin pick: first eligible request after `last`, wrapping at N_INITIATORS.
module wb_arb_rr_pick #(
  parameter int unsigned N_INITIATORS = 2,
  parameter int unsigned IDX_WIDTH    = $clog2(N_INITIATORS)
) (
  input  logic [N_INITIATORS-1:0] req,
  input  logic [IDX_WIDTH-1:0]    last,
  input  logic [N_INITIATORS-1:0] mask,
  output logic [IDX_WIDTH-1:0]    pick,
  output logic                    any
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_INITIATORS - 1);

  logic [N_INITIATORS-1:0] eligible;
  logic [IDX_WIDTH-1:0]    cur;
  logic                    found;

  // Explicit wrap keeps non-power-of-two initiator counts in range.
  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_WIDTH'(1);
  endfunction

  always_comb begin
    eligible = req & ~mask;
    any      = |eligible;
    pick     = '0;
    found    = 1'b0;
    cur      = next_idx(last);
    for (int unsigned i = 0; i < N_INITIATORS; i++) begin
      if (!found && eligible[cur]) begin
        pick  = cur;
        found = 1'b1;
      end
      cur = next_idx(cur);
    end
  end

endmodule

// File: rtl/wb_interconnect_arb_rr.sv
// Per-target round-robin arbiter holding ownership for a whole Wishbone cycle.
// Optional grant watchdog enabled by FW_WB_INTERCONNECT_ARB_TIMEOUT_EN.
module wb_interconnect_arb_rr
  import wb_interconnect_arb_pkg::*;
#(
  parameter int unsigned N_INITIATORS   = 2,
  parameter int unsigned IDX_WIDTH      = $clog2(N_INITIATORS),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_INITIATORS-1:0] req,
  input  logic [N_INITIATORS-1:0] cyc,
  output logic [N_INITIATORS-1:0] gnt,
  output logic [IDX_WIDTH-1:0]    gnt_idx,
  output logic                    gnt_valid,
  output logic                    timeout
);

  localparam logic [N_INITIATORS-1:0] ONE = N_INITIATORS'(1);

  if (N_INITIATORS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("wb_interconnect_arb_rr: N_INITIATORS and TIMEOUT_CYCLES must be >= 2");
  end

  state_t                  state;
  logic [IDX_WIDTH-1:0]    last;
  logic [N_INITIATORS-1:0] mask;
  logic [IDX_WIDTH-1:0]    pick;
  logic                    any;
  logic                    owner_cyc;
  logic                    expire;

  assign owner_cyc = cyc[gnt_idx];

`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] held;
  assign expire = (state == GRANT) && owner_cyc && (held == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // The expiring owner is excluded only from the forced re-pick.
  assign mask = expire ? (ONE << gnt_idx) : '0;

  wb_arb_rr_pick #(
    .N_INITIATORS(N_INITIATORS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_pick (
    .req (req),
    .last(last),
    .mask(mask),
    .pick(pick),
    .any (any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      last      <= IDX_WIDTH'(N_INITIATORS - 1);
`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
      held      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
      timeout <= expire;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            state     <= GRANT;
            gnt       <= ONE << pick;
            gnt_idx   <= pick;
            last      <= pick;
            gnt_valid <= 1'b1;
`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
            held      <= '0;
`endif
          end
        end
        GRANT: begin
          if (owner_cyc && !expire) begin
`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
            held <= held + CW'(1);
`endif
          end else if (any) begin
            gnt       <= ONE << pick;
            gnt_idx   <= pick;
            last      <= pick;
            gnt_valid <= 1'b1;
`ifdef FW_WB_INTERCONNECT_ARB_TIMEOUT_EN
            held      <= '0;
`endif
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_interconnect_arb_rr.md
# wb_interconnect_arb_rr

Per-target round-robin arbiter for the tagged Wishbone NxN interconnect. One instance sits in front of each target port and decides which initiator owns that target. It drives the one-hot grant used by the crossbar mux and the encoded grant index consumed as that target's slice of `target_initiator` by the interconnect debug monitor. Ownership is held for a whole Wishbone cycle (`cyc` high), so block transfers are never split.

## Interface
- `N_INITIATORS`, 2: number of competing initiators; must be ≥2.
- `IDX_WIDTH`, `$clog2(N_INITIATORS)`: width of the encoded grant index; derived, not overridden.
- `TIMEOUT_CYCLES`, 1024: watchdog limit on grant duration; used only with the `Configuration` macro; must be ≥2.
- `clock`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_INITIATORS  per-initiator request: `cyc & stb & address-hit` for this target.
- `cyc`  in  N_INITIATORS  per-initiator raw `cyc`; the owner's bit holds the grant.
- `gnt`  out  N_INITIATORS  one-hot grant; all-zero when idle.
- `gnt_idx`  out  IDX_WIDTH  encoded owner; holds the last owner when idle.
- `gnt_valid`  out  1  high while any grant is active (equals `|gnt`).
- `timeout`  out  1  one-cycle pulse on forced release; tied 0 without the macro.

## Operation
- States: IDLE, GRANT.
- Reset values:
  - state = IDLE.
  - `gnt` = 0.
  - `gnt_idx` = 0.
  - `gnt_valid` = 0.
  - `timeout` = 0.
  - last-owner pointer = N_INITIATORS-1, so initiator 0 has first priority.
- Pick function: the first set bit of `req`, scanning from `last+1` upward and wrapping modulo N_INITIATORS. Index arithmetic is IDX_WIDTH bits with explicit wrap at N_INITIATORS, so non-power-of-two counts are handled.
- IDLE → GRANT: when `req != 0`. Register `gnt = onehot(pick)`, `gnt_idx = pick`, `last = pick`.
- GRANT, hold: stay while `cyc[gnt_idx]` is high. Changes on other `req` bits are ignored.
- GRANT, owner `cyc` low, other requests pending: if `req != 0` (the owner's bit is necessarily 0), hand off directly to the next pick. No idle cycle is inserted.
- GRANT, owner `cyc` low, no requests: go to IDLE and clear `gnt`/`gnt_valid`.
- Simultaneous events:
  - Release and new requests in the same cycle resolve as a handoff.
  - Several requests in IDLE resolve by round-robin order.
  - A single persistent requester is re-granted in consecutive cycles.
- Reset mid-grant: all outputs drop asynchronously to their reset values. The pointer returns to N_INITIATORS-1.

## Timing
- Grant latency: 1 cycle. A request sampled at edge k gives `gnt` valid after edge k.
- Release latency: 1 cycle. `cyc` low sampled at edge k gives the new `gnt` (or 0) after edge k.
- All outputs are registered. There is no combinational path from `req`/`cyc` to any output.
- Fairness: with all N requesting and each holding for one cycle, every initiator is granted once in every N consecutive grants.

## Configuration
- Macro: `FW_WB_INTERCONNECT_ARB_TIMEOUT_EN`.
- Defined: a counter clears on every new grant and increments each GRANT cycle. When the owner has held for TIMEOUT_CYCLES cycles with `cyc` still high:
  - release is forced: the arbiter re-picks with the owner's bit masked for that one decision, or goes to IDLE if nothing else is requested;
  - `timeout` pulses for 1 cycle, aligned with the new `gnt`;
  - the masked owner may be re-granted on the following arbitration.
- Undefined: no counter is built, `timeout` is tied 0, and a grant lasts until `cyc` falls.

## Structure
- Shared package `wb_interconnect_arb_pkg` holds:
  - the state encoding constants (IDLE=0, GRANT=1);
  - the timeout counter width function `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `wb_arb_rr_pick`: purely combinational. Takes `req`, `last` and `mask` and returns `pick`/`any`. It is reused by the interconnect for every target.
- One arbiter instance per target in the interconnect. Concatenated `gnt_idx` outputs form `target_initiator`.

## Test plan
All scenarios use N_INITIATORS=4; the timeout scenario uses TIMEOUT_CYCLES=8.
- Reset then `req=4'b0000` for 5 cycles → `gnt=0`, `gnt_valid=0`, `gnt_idx=0`; assert reset mid-grant → outputs return to 0 immediately, without waiting for a clock edge.
- `req=cyc=4'b1111`, each owner drops `cyc` after 1 cycle and reasserts → grant sequence 0,1,2,3,0 with no idle cycles.
- Initiator 2 alone holds `cyc` for 6 cycles while `req=4'b1011` from others → `gnt=4'b0100` for 6 cycles, then `gnt_idx=3` (wrap order 3,0,1).
- Owner 1 drops `cyc` while `req=0` → next cycle `gnt=0`, `gnt_idx` stays 1; new `req[1]` → `gnt=4'b0010` one cycle later.
- Macro defined: initiator 0 holds `cyc` for 20 cycles with `req[3]` pending → after 8 grant cycles `gnt=4'b1000`, `timeout` high for exactly 1 cycle.
- Macro undefined, same stimulus → `gnt=4'b0001` for all 20 cycles, `timeout` never asserted.
